multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Moore FSM sequencer for the multicycle RV32I datapath: one shared ALU, single memory port for instruction and data, IR/oldPC/ALUOut/Data registers.
- Steps each instruction through fetch/decode/execute/memory/writeback and drives every datapath enable and mux select.
- Replaces the single-cycle decoder.
- Handshakes with memory through a req/ready pair, which allows wait states.

Parameters:
- None. All encodings come from the shared package.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- instr  in  32  IR contents; valid from DECODE onward
- Zero  in  1  ALU zero flag, same cycle
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request
- MemWrite  out  1  store strobe; only with mem_req
- AdrSrc  out  1  0 = PC, 1 = ALUOut
- IRWrite  out  1  latch IR and oldPC
- PCWrite  out  1  PC enable
- RegWrite  out  1  register file write
- ALUSrcA  out  2  00 PC, 01 oldPC, 10 rs1, 11 zero
- ALUSrcB  out  2  00 rs2, 01 imm, 10 const 4
- ResultSrc  out  2  00 ALUOut, 01 Data reg, 10 ALU result direct
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 U, 100 J
- ALUctrl  out  4  {funct7[5], funct3}-style encoding; ADD 0000, SUB 1000, SLT 0010, SLTU 0011
- retire  out  1  one-cycle pulse in an instruction's final cycle

Behaviour:
- Reset and outputs:
  - One clock; rst is asynchronous and active-high and forces state IDLE.
  - In IDLE all outputs are 0. IDLE -> FETCH unconditionally.
  - Outputs not listed for a state are 0.
  - Outputs are decoded combinationally from state and instr only; they never depend on Zero or mem_ready except where stated.
- FETCH:
  - Drives mem_req=1, AdrSrc=0, SrcA=00, SrcB=10, ADD, ResultSrc=10.
  - IRWrite and PCWrite equal mem_ready.
  - Holds until mem_ready, then -> DECODE.
- DECODE:
  - Drives SrcA=01, SrcB=01, ADD. ImmSrc=J if op is JAL, else B; ALUOut captures the branch/jump target.
  - Next state by opcode: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR; 0110111 -> LUI; anything else -> ILLEGAL.
- MEMADR:
  - Drives SrcA=10, SrcB=01, ADD; ImmSrc=I for load, S for store.
  - -> MEMREAD (load) or MEMWRITE (store).
- MEMREAD:
  - Drives mem_req, AdrSrc=1.
  - Waits for mem_ready, then -> MEMWB.
- MEMWB:
  - Drives ResultSrc=01, RegWrite, retire.
  - -> FETCH.
- MEMWRITE:
  - Drives mem_req, MemWrite, AdrSrc=1; retire=mem_ready.
  - Waits for mem_ready, then -> FETCH.
- EXECR:
  - Drives SrcA=10, SrcB=00, ALUctrl={funct7[5], funct3}.
  - -> ALUWB.
- EXECI:
  - Drives SrcA=10, SrcB=01, ImmSrc=I.
  - ALUctrl={funct3==101 ? funct7[5] : 0, funct3}; addi never becomes SUB.
  - -> ALUWB.
- LUI:
  - Drives SrcA=11, SrcB=01, ImmSrc=U, ADD.
  - -> ALUWB.
- ALUWB:
  - Drives ResultSrc=00, RegWrite, retire.
  - -> FETCH.
- BRANCH:
  - Drives SrcA=10, SrcB=00, ResultSrc=00, retire.
  - ALU op and PCWrite by funct3:
    - beq: SUB, PCWrite=Zero
    - bne: SUB, PCWrite=!Zero
    - blt: SLT, PCWrite=!Zero
    - bge: SLT, PCWrite=Zero
    - bltu: SLTU, PCWrite=!Zero
    - bgeu: SLTU, PCWrite=Zero
    - funct3 010/011: PCWrite=0
  - -> FETCH.
- JAL:
  - Drives PCWrite, ResultSrc=00 (target), SrcA=01, SrcB=10, ADD (ALUOut <- oldPC+4).
  - -> ALUWB.
- JALR:
  - Drives SrcA=10, SrcB=01, ImmSrc=I, ADD, ResultSrc=10, PCWrite.
  - -> LINK.
- LINK:
  - Drives SrcA=01, SrcB=10, ADD, ResultSrc=10, RegWrite, retire.
  - -> FETCH.
- Latency with zero wait states (mem_ready already high):
  - Branch 3 cycles; store 4; R/I/LUI/JAL 4; JALR 4; load 5.
  - Each wait cycle adds one.
- Boundary conditions:
  - mem_ready outside FETCH, MEMREAD and MEMWRITE is ignored.
  - rst mid-MEMWRITE drops MemWrite and mem_req in the same cycle, asynchronously.
  - rd==rs1 on JALR is safe: rs1 is consumed in JALR, rd is written in LINK.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined:
  - ILLEGAL is a sticky state driving output trap=1 (extra 1-bit port) with all other outputs 0.
  - Exits only on rst.
- Undefined:
  - No trap port.
  - ILLEGAL retires as a NOP: retire=1, -> FETCH.

Decomposition:
- Package ctrl_pkg:
  - state enum
  - opcode constants
  - ALUctrl, ImmSrc, ALUSrcA/B and ResultSrc encodings as localparams or enums
- Sub-module: branch_ctrl (combinational), mapping funct3 and Zero to {ALUctrl, take}; used only in BRANCH.

Test Plan:
- Reset released, mem_ready=1, instr=add x3,x1,x2 (0x002081B3):
  - states IDLE, FETCH, DECODE, EXECR, ALUWB
  - EXECR ALUctrl=0000
  - retire on the 5th cycle after reset release
- lw x5,8(x1), mem_ready low 2 cycles in MEMREAD:
  - MEMREAD held 3 cycles with mem_req=1, AdrSrc=1
  - MEMWB RegWrite=1, ResultSrc=01; total 7 cycles
- sw with mem_ready=1: MEMWRITE asserts MemWrite=1, retire=1 same cycle, -> FETCH.
- blt: Zero=0 -> PCWrite=1, ALUctrl=0010; Zero=1 -> PCWrite=0.
- bgeu: Zero=1 -> PCWrite=1, ALUctrl=0011.
- jalr x1,0(x1): JALR cycle PCWrite=1, ResultSrc=10; LINK cycle RegWrite=1, SrcA=01, SrcB=10.
- Opcode 0x7F:
  - with ILLEGAL_TRAP_EN: trap=1 persists 10 cycles; rst clears it to IDLE
  - without: retire pulse, then FETCH
- rst asserted mid-MEMWRITE: MemWrite=0 immediately (asynchronous).

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared state, opcode and datapath-select encodings for the multicycle RV32I controller
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
        S_EXECI, S_LUI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LINK, S_ILLEGAL
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // Opcode dispatch out of DECODE; unknown opcodes land in ILLEGAL
    function automatic state_t decode_next(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE: return S_MEMADR;
            OP_R:              return S_EXECR;
            OP_I:              return S_EXECI;
            OP_BRANCH:         return S_BRANCH;
            OP_JAL:            return S_JAL;
            OP_JALR:           return S_JALR;
            OP_LUI:            return S_LUI;
            default:           return S_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/branch_ctrl.sv
// branch_ctrl: maps branch funct3 and the ALU zero flag to the compare op and the take decision
module branch_ctrl
    import ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       zero,
    output logic [3:0] alu_ctrl,
    output logic       take
);

    // eq/ne compare by SUB; signed/unsigned less-than by SLT/SLTU, where zero means "not less".
    // funct3[0] inverts the sense; 010/011 are not branches and never take.
    always_comb begin
        alu_ctrl = !funct3[2] ? ALU_SUB : (funct3[1] ? ALU_SLTU : ALU_SLT);
        take     = (funct3[2:1] == 2'b01) ? 1'b0 : (zero ^ funct3[0] ^ funct3[2]);
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore sequencer for the multicycle RV32I datapath; ILLEGAL_TRAP_EN adds a sticky trap state and port
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        MemWrite,
    output logic        AdrSrc,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [2:0]  ImmSrc,
    output logic [3:0]  ALUctrl,
`ifdef ILLEGAL_TRAP_EN
    output logic        trap,
`endif
    output logic        retire
);

    state_t     state_q, state_d;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       f7b5;
    logic [3:0] br_alu;
    logic       br_take;
    logic       unused_bits;

    assign op          = instr[6:0];
    assign funct3      = instr[14:12];
    assign f7b5        = instr[30];
    assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

    branch_ctrl u_branch (
        .funct3   (funct3),
        .zero     (Zero),
        .alu_ctrl (br_alu),
        .take     (br_take)
    );

    // State register; asynchronous reset so outputs drop the moment rst rises
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state and per-state datapath controls; anything not driven in a state stays 0
    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        MemWrite  = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        ResultSrc = RES_ALUOUT;
        ImmSrc    = IMM_I;
        ALUctrl   = ALU_ADD;
        retire    = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        trap      = 1'b0;
`endif
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                state_d   = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
                state_d = decode_next(op);
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = (op == OP_STORE) ? IMM_S : IMM_I;
                state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
                retire   = mem_ready;
                state_d  = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RS1;
                ALUctrl = {f7b5, funct3};
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ALUctrl = {(funct3 == 3'b101) & f7b5, funct3};
                state_d = S_ALUWB;
            end
            S_LUI: begin
                ALUSrcA = SRCA_ZERO;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_U;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA = SRCA_RS1;
                ALUctrl = br_alu;
                PCWrite = br_take;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                PCWrite = 1'b1;
                state_d = S_ALUWB;
            end
            S_JALR: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALU;
                PCWrite   = 1'b1;
                state_d   = S_LINK;
            end
            S_LINK: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                RegWrite  = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_ILLEGAL: begin
`ifdef ILLEGAL_TRAP_EN
                trap    = 1'b1;
`else
                retire  = 1'b1;
                state_d = S_FETCH;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
